grf_wb_arbiter: RTL and testbench

//  Shares the single GRF write port between the in-order pipeline WB stage and the

---
 rtl/grf_wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the WB stage and the MDU result FIFO,
// and tracks registers awaiting MDU results. Optional trace: define GRF_WB_ARB_TRACE_EN.
module grf_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_reg,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_hold,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_reg,
  input  logic        mdu_wb_valid,
  input  logic [4:0]  mdu_wb_reg,
  input  logic [31:0] mdu_wb_data,
  output logic        mdu_wb_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        id_stall,
  output logic [31:0] busy_vec,
  output logic        grf_regwrite,
  output logic [4:0]  grf_writereg,
  output logic [31:0] grf_writedata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);

  logic [4:0]    reg_mem_r  [DEPTH];
  logic [31:0]   data_mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic [CW-1:0] starve_cnt_r;
  logic [31:0]   busy_r;

  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          mdu_gnt_s;
  logic          pipe_gnt_s;
  logic [4:0]    head_reg_s;
  logic [31:0]   head_data_s;
  logic [31:0]   busy_next_s;

  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign head_reg_s  = reg_mem_r[rd_ptr_r[AW-1:0]];
  assign head_data_s = data_mem_r[rd_ptr_r[AW-1:0]];
  assign push_s      = mdu_wb_valid && mdu_wb_ready;
  assign busy_vec    = busy_r;

  // Grant decision and all port-facing combinational outputs, forced idle during reset.
  always_comb begin
    mdu_gnt_s     = 1'b0;
    pipe_gnt_s    = 1'b0;
    pipe_hold     = 1'b0;
    mdu_wb_ready  = 1'b0;
    id_stall      = 1'b0;
    grf_regwrite  = 1'b0;
    grf_writereg  = 5'd0;
    grf_writedata = 32'd0;
    if (reset) begin
      mdu_gnt_s  = 1'b0;
      pipe_gnt_s = 1'b0;
    end else begin
      mdu_gnt_s    = !empty_s && (!pipe_wb_valid || (starve_cnt_r == MAX_WAIT_C));
      pipe_gnt_s   = pipe_wb_valid && !mdu_gnt_s;
      pipe_hold    = pipe_wb_valid && mdu_gnt_s;
      mdu_wb_ready = !full_s;
      id_stall     = ((id_rs != 5'd0) && busy_r[id_rs]) || ((id_rt != 5'd0) && busy_r[id_rt]);
      if (mdu_gnt_s) begin
        // $0 results still drain the FIFO but never reach the register file
        grf_regwrite  = (head_reg_s != 5'd0);
        grf_writereg  = head_reg_s;
        grf_writedata = head_data_s;
      end else if (pipe_gnt_s) begin
        grf_regwrite  = 1'b1;
        grf_writereg  = pipe_wb_reg;
        grf_writedata = pipe_wb_data;
      end else begin
        grf_regwrite  = 1'b0;
        grf_writereg  = 5'd0;
        grf_writedata = 32'd0;
      end
    end
  end

  // Scoreboard next state: a new issue overrides a same-cycle completion.
  always_comb begin
    busy_next_s = busy_r;
    if (mdu_gnt_s) begin
      busy_next_s[head_reg_s] = 1'b0;
    end else begin
      busy_next_s = busy_r;
    end
    if (mdu_issue && (mdu_issue_reg != 5'd0)) begin
      busy_next_s[mdu_issue_reg] = 1'b1;
    end else begin
      busy_next_s[0] = 1'b0;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      reg_mem_r[wr_ptr_r[AW-1:0]]  <= mdu_wb_reg;
      data_mem_r[wr_ptr_r[AW-1:0]] <= mdu_wb_data;
    end
  end

  // FIFO pointers, starvation counter and scoreboard state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      starve_cnt_r <= '0;
      busy_r       <= 32'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (mdu_gnt_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (empty_s || mdu_gnt_s) begin
        starve_cnt_r <= '0;
      end else if (pipe_gnt_s && (starve_cnt_r != MAX_WAIT_C)) begin
        starve_cnt_r <= starve_cnt_r + CW'(1);
      end
      busy_r <= busy_next_s;
    end
  end

`ifdef GRF_WB_ARB_TRACE_EN
  // Write-port and protocol-error trace.
  always @(posedge clk) begin
    if (!reset && grf_regwrite) begin
      $display("%d arb: %s $%d <= %h", $time, mdu_gnt_s ? "MDU " : "PIPE", grf_writereg, grf_writedata);
    end
    if (!reset && mdu_issue && busy_r[mdu_issue_reg]) begin
      $display("%d arb: ERROR reissue $%d", $time, mdu_issue_reg);
    end
  end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed self-checking bench for grf_wb_arbiter (DEPTH=2, MAX_WAIT=3).
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_reg;
  logic [31:0] pipe_wb_data;
  logic        pipe_hold;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_reg;
  logic        mdu_wb_valid;
  logic [4:0]  mdu_wb_reg;
  logic [31:0] mdu_wb_data;
  logic        mdu_wb_ready;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_stall;
  logic [31:0] busy_vec;
  logic        grf_regwrite;
  logic [4:0]  grf_writereg;
  logic [31:0] grf_writedata;

  int n_checks = 0;
  int n_fail   = 0;

  grf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_reg(pipe_wb_reg), .pipe_wb_data(pipe_wb_data),
    .pipe_hold(pipe_hold),
    .mdu_issue(mdu_issue), .mdu_issue_reg(mdu_issue_reg),
    .mdu_wb_valid(mdu_wb_valid), .mdu_wb_reg(mdu_wb_reg), .mdu_wb_data(mdu_wb_data),
    .mdu_wb_ready(mdu_wb_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_stall(id_stall), .busy_vec(busy_vec),
    .grf_regwrite(grf_regwrite), .grf_writereg(grf_writereg), .grf_writedata(grf_writedata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wb_valid = 1'b0; pipe_wb_reg = 5'd0; pipe_wb_data = 32'd0;
    mdu_issue = 1'b0; mdu_issue_reg = 5'd0;
    mdu_wb_valid = 1'b0; mdu_wb_reg = 5'd0; mdu_wb_data = 32'd0;
    id_rs = 5'd0; id_rt = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pipe_wb_valid = 1'b1; pipe_wb_reg = 5'd7; pipe_wb_data = 32'h0000_0077;
    mdu_issue = 1'b1; mdu_issue_reg = 5'd8;
    mdu_wb_valid = 1'b1; mdu_wb_reg = 5'd8; mdu_wb_data = 32'h1234_5678;
    id_rs = 5'd8; id_rt = 5'd8;
    #1;
    n_checks++; if (grf_regwrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite got=%b exp=0", grf_regwrite); end
    n_checks++; if (mdu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", mdu_wb_ready); end
    n_checks++; if (pipe_hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold got=%b exp=0", pipe_hold); end
    step();
    step();
    n_checks++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL rst_busy got=%h exp=0", busy_vec); end
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", id_stall); end
    n_checks++; if (grf_regwrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite2 got=%b exp=0", grf_regwrite); end
    reset = 1'b0;
    idle_inputs();
    #1;
    n_checks++; if (mdu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got=%b exp=1", mdu_wb_ready); end
    n_checks++; if (grf_regwrite !== 1'b0) begin n_fail++; $display("FAIL post_rst_empty got=%b exp=0", grf_regwrite); end
    step();
  endtask

  task automatic test_basic_mdu();
    mdu_issue = 1'b1; mdu_issue_reg = 5'd8; id_rs = 5'd8;
    #1;
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL issue_stall_early got=%b exp=0", id_stall); end
    step();
    mdu_issue = 1'b0;
    mdu_wb_valid = 1'b1; mdu_wb_reg = 5'd8; mdu_wb_data = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL issue_stall got=%b exp=1", id_stall); end
    n_checks++; if (busy_vec !== 32'h0000_0100) begin n_fail++; $display("FAIL issue_busy got=%h exp=00000100", busy_vec); end
    n_checks++; if (grf_regwrite !== 1'b0) begin n_fail++; $display("FAIL no_passthru got=%b exp=0", grf_regwrite); end
    step();
    mdu_wb_valid = 1'b0;
    #1;
    n_checks++; if (grf_regwrite !== 1'b1) begin n_fail++; $display("FAIL mdu_wr got=%b exp=1", grf_regwrite); end
    n_checks++; if (grf_writereg !== 5'd8) begin n_fail++; $display("FAIL mdu_reg got=%0d exp=8", grf_writereg); end
    n_checks++; if (grf_writedata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mdu_data got=%h exp=deadbeef", grf_writedata); end
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL stall_no_bypass got=%b exp=1", id_stall); end
    step();
    n_checks++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL busy_clear got=%h exp=0", busy_vec); end
    n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL stall_fall got=%b exp=0", id_stall); end
    n_checks++; if (grf_regwrite !== 1'b0) begin n_fail++; $display("FAIL drained got=%b exp=0", grf_regwrite); end
    idle_inputs();
  endtask

  task automatic test_starvation();
    pipe_wb_valid = 1'b1; pipe_wb_reg = 5'd3; pipe_wb_data = 32'h0000_00A0;
    mdu_wb_valid = 1'b1; mdu_wb_reg = 5'd9; mdu_wb_data = 32'h9999_0009;
    #1;
    n_checks++; if (grf_writereg !== 5'd3 || pipe_hold !== 1'b0) begin n_fail++; $display("FAIL starve_pre got=%0d/%b exp=3/0", grf_writereg, pipe_hold); end
    step();
    mdu_wb_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (grf_writereg !== 5'd3 || pipe_hold !== 1'b0 || grf_regwrite !== 1'b1) begin
        n_fail++; $display("FAIL starve_pipe_win%0d got=%0d/%b exp=3/0", i, grf_writereg, pipe_hold);
      end
      step();
    end
    #1;
    n_checks++; if (pipe_hold !== 1'b1) begin n_fail++; $display("FAIL starve_hold got=%b exp=1", pipe_hold); end
    n_checks++; if (grf_writereg !== 5'd9 || grf_writedata !== 32'h9999_0009) begin n_fail++; $display("FAIL starve_forced got=%0d/%h exp=9/99990009", grf_writereg, grf_writedata); end
    step();
    n_checks++; if (pipe_hold !== 1'b0 || grf_writereg !== 5'd3 || grf_regwrite !== 1'b1) begin n_fail++; $display("FAIL starve_pipe_lands got=%0d/%b exp=3/0", grf_writereg, pipe_hold); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    pipe_wb_valid = 1'b1; pipe_wb_reg = 5'd4; pipe_wb_data = 32'h0000_0044;
    mdu_wb_valid = 1'b1; mdu_wb_reg = 5'd10; mdu_wb_data = 32'hAAAA_0001;
    #1;
    n_checks++; if (mdu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0 got=%b exp=1", mdu_wb_ready); end
    step();
    mdu_wb_reg = 5'd11; mdu_wb_data = 32'hBBBB_0002;
    #1;
    n_checks++; if (mdu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got=%b exp=1", mdu_wb_ready); end
    n_checks++; if (grf_writereg !== 5'd4 || pipe_hold !== 1'b0) begin n_fail++; $display("FAIL b2b_pipe got=%0d/%b exp=4/0", grf_writereg, pipe_hold); end
    step();
    mdu_wb_valid = 1'b0; pipe_wb_valid = 1'b0;
    #1;
    n_checks++; if (mdu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got=%b exp=0", mdu_wb_ready); end
    n_checks++; if (grf_writereg !== 5'd10 || grf_writedata !== 32'hAAAA_0001) begin n_fail++; $display("FAIL b2b_first got=%0d/%h exp=10/aaaa0001", grf_writereg, grf_writedata); end
    step();
    n_checks++; if (mdu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2 got=%b exp=1", mdu_wb_ready); end
    n_checks++; if (grf_writereg !== 5'd11 || grf_writedata !== 32'hBBBB_0002) begin n_fail++; $display("FAIL b2b_second got=%0d/%h exp=11/bbbb0002", grf_writereg, grf_writedata); end
    step();
    n_checks++; if (grf_regwrite !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got=%b exp=0", grf_regwrite); end
  endtask

  task automatic test_reg_zero();
    mdu_wb_valid = 1'b1; mdu_wb_reg = 5'd0; mdu_wb_data = 32'h0000_0055;
    step();
    mdu_wb_reg = 5'd12; mdu_wb_data = 32'hC0C0_C0C0;
    #1;
    n_checks++; if (grf_regwrite !== 1'b0) begin n_fail++; $display("FAIL r0_regwrite got=%b exp=0", grf_regwrite); end
    n_checks++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL r0_busy got=%h exp=0", busy_vec); end
    step();
    mdu_wb_valid = 1'b0;
    #1;
    n_checks++; if (grf_regwrite !== 1'b1 || grf_writereg !== 5'd12) begin n_fail++; $display("FAIL r0_popped got=%b/%0d exp=1/12", grf_regwrite, grf_writereg); end
    step();
    idle_inputs();
  endtask

  task automatic test_set_wins();
    mdu_issue = 1'b1; mdu_issue_reg = 5'd5;
    step();
    mdu_issue = 1'b0;
    mdu_wb_valid = 1'b1; mdu_wb_reg = 5'd5; mdu_wb_data = 32'h5555_0005;
    step();
    mdu_wb_valid = 1'b0;
    mdu_issue = 1'b1; mdu_issue_reg = 5'd5;
    #1;
    n_checks++; if (grf_writereg !== 5'd5 || grf_regwrite !== 1'b1) begin n_fail++; $display("FAIL sw_grant got=%b/%0d exp=1/5", grf_regwrite, grf_writereg); end
    step();
    mdu_issue = 1'b0; id_rt = 5'd5;
    #1;
    n_checks++; if (busy_vec !== 32'h0000_0020) begin n_fail++; $display("FAIL sw_busy got=%h exp=00000020", busy_vec); end
    n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL sw_stall_rt got=%b exp=1", id_stall); end
    mdu_wb_valid = 1'b1; mdu_wb_reg = 5'd5; mdu_wb_data = 32'h5555_0006;
    step();
    mdu_wb_valid = 1'b0;
    step();
    n_checks++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL sw_clear got=%h exp=0", busy_vec); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    pipe_wb_valid = 1'b1; pipe_wb_reg = 5'd2; pipe_wb_data = 32'h0000_0022;
    mdu_issue = 1'b1; mdu_issue_reg = 5'd14;
    mdu_wb_valid = 1'b1; mdu_wb_reg = 5'd13; mdu_wb_data = 32'hD0D0_0013;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_checks++; if (busy_vec !== 32'd0) begin n_fail++; $display("FAIL midrst_busy got=%h exp=0", busy_vec); end
    n_checks++; if (grf_regwrite !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo got=%b exp=0", grf_regwrite); end
    n_checks++; if (mdu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", mdu_wb_ready); end
    step();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_mdu();
    test_starvation();
    test_back_to_back();
    test_reg_zero();
    test_set_wins();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
